// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the 16-bit RISC multicycle controller and datapath:
// state codes, opcodes, ALU select codes and the packed control word.
package risc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_WB_R     = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_EXEC_LHI = 4'd5,
    ST_WB_I     = 4'd6,
    ST_ADDR     = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_HALT     = 4'd13,
    ST_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_BEQ  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_LHI  = 4'b1001;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] SRCB_B     = 3'b000;
  localparam logic [2:0] SRCB_ONE   = 3'b001;
  localparam logic [2:0] SRCB_IMM6  = 3'b010;
  localparam logic [2:0] SRCB_HI8   = 3'b100;
  localparam logic [2:0] SRCB_IMM12 = 3'b101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNC  = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       alu_srcA;
    logic [2:0] alu_srcB;
    logic [1:0] alu_op;
    logic       pc_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  // Dispatch target out of DECODE; unknown opcodes trap.
  function automatic state_t decode_next(input logic [3:0] op);
    state_t nxt;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: nxt = ST_EXEC_R;
      OP_ADDI:                       nxt = ST_EXEC_I;
      OP_LHI:                        nxt = ST_EXEC_LHI;
      OP_LW, OP_SW:                  nxt = ST_ADDR;
      OP_BEQ:                        nxt = ST_BRANCH;
      OP_JMP:                        nxt = ST_JUMP;
      OP_HALT:                       nxt = ST_HALT;
      default:                       nxt = ST_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore decode from controller state to the datapath control word.
// FETCH additionally qualifies ir_write/pc_write with the memory handshake.
module ctrl_out_decode
  import risc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control word; anything not set stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read = 1'b1;
        ctrl.alu_srcB = SRCB_ONE;
        ctrl.alu_op   = ALU_ADD;
        ctrl.ir_write = mem_ready;
        ctrl.pc_write = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_srcB = SRCB_IMM6;
        ctrl.alu_op   = ALU_ADD;
      end
      ST_EXEC_R: begin
        ctrl.alu_srcA = 1'b1;
        ctrl.alu_srcB = SRCB_B;
        ctrl.alu_op   = ALU_FUNC;
      end
      ST_WB_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_EXEC_I, ST_ADDR: begin
        ctrl.alu_srcA = 1'b1;
        ctrl.alu_srcB = SRCB_IMM6;
        ctrl.alu_op   = ALU_ADD;
      end
      ST_EXEC_LHI: begin
        ctrl.alu_srcB = SRCB_HI8;
        ctrl.alu_op   = ALU_PASSB;
      end
      ST_WB_I: begin
        ctrl.reg_write = 1'b1;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_srcA      = 1'b1;
        ctrl.alu_srcB      = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 1'b1;
      end
      ST_JUMP: begin
        ctrl.alu_srcB = SRCB_IMM12;
        ctrl.alu_op   = ALU_ADD;
        ctrl.pc_write = 1'b1;
      end
      ST_HALT: begin
        ctrl.halted = 1'b1;
      end
      ST_ILLEGAL: begin
        ctrl.halted  = 1'b1;
        ctrl.illegal = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit RISC datapath.
// Define MULTICYCLE_CTRL_MEM_WAIT_EN to honour mem_ready; otherwise memory is zero-wait.
module multicycle_ctrl
  import risc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       alu_srcA,
  output logic [2:0] alu_srcB,
  output logic [1:0] alu_op,
  output logic       pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_r;
  logic   is_store_r;
  logic   mem_ready_s;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_out_s;
  logic   unused_s;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_ready_s = mem_ready;
  assign unused_s    = zero;
`else
  assign mem_ready_s = 1'b1;
  assign unused_s    = zero ^ mem_ready;
`endif

  // State register and next-state logic; LW/SW choice is latched in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      is_store_r <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH:    state_r <= mem_ready_s ? ST_DECODE : ST_FETCH;
        ST_DECODE: begin
          is_store_r <= (opcode == OP_SW);
          state_r    <= decode_next(opcode);
        end
        ST_EXEC_R:   state_r <= ST_WB_R;
        ST_EXEC_I:   state_r <= ST_WB_I;
        ST_EXEC_LHI: state_r <= ST_WB_I;
        ST_ADDR:     state_r <= is_store_r ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD:   state_r <= mem_ready_s ? ST_WB_MEM : ST_MEM_RD;
        ST_MEM_WR:   state_r <= mem_ready_s ? ST_FETCH : ST_MEM_WR;
        ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP:
                     state_r <= ST_FETCH;
        ST_HALT:     state_r <= ST_HALT;
        ST_ILLEGAL:  state_r <= ST_ILLEGAL;
        default:     state_r <= ST_ILLEGAL;
      endcase
    end
  end

  ctrl_out_decode u_decode (
    .state     (state_r),
    .mem_ready (mem_ready_s),
    .ctrl      (ctrl_s)
  );

  // Reset wins immediately so an in-flight strobe never survives an rst cycle.
  always_comb begin
    if (rst) begin
      ctrl_out_s = '0;
      state      = 4'd0;
    end else begin
      ctrl_out_s = ctrl_s;
      state      = state_r;
    end
  end

  assign pc_write      = ctrl_out_s.pc_write;
  assign pc_write_cond = ctrl_out_s.pc_write_cond;
  assign ir_write      = ctrl_out_s.ir_write;
  assign reg_write     = ctrl_out_s.reg_write;
  assign mem_read      = ctrl_out_s.mem_read;
  assign mem_write     = ctrl_out_s.mem_write;
  assign i_or_d        = ctrl_out_s.i_or_d;
  assign alu_srcA      = ctrl_out_s.alu_srcA;
  assign alu_srcB      = ctrl_out_s.alu_srcB;
  assign alu_op        = ctrl_out_s.alu_op;
  assign pc_src        = ctrl_out_s.pc_src;
  assign reg_dst       = ctrl_out_s.reg_dst;
  assign mem_to_reg    = ctrl_out_s.mem_to_reg;
  assign halted        = ctrl_out_s.halted;
  assign illegal       = ctrl_out_s.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against an instruction-level model.
module tb_multicycle_ctrl;
  import risc_ctrl_pkg::*;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, ir_write, reg_write;
  logic       mem_read, mem_write, i_or_d, alu_srcA;
  logic [2:0] alu_srcB;
  logic [1:0] alu_op;
  logic       pc_src, reg_dst, mem_to_reg, halted, illegal;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_op(alu_op),
    .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .halted(halted), .illegal(illegal), .state(state)
  );

  wire [18:0] obs = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                     i_or_d, alu_srcA, alu_srcB, alu_op, pc_src, reg_dst, mem_to_reg,
                     halted, illegal};

  // Expected control word for one phase of an instruction, straight from the phase table.
  function automatic logic [18:0] exp_ctrl(input state_t p, input logic mr);
    logic pcw = 0, pcwc = 0, irw = 0, rw = 0, mrd = 0, mwr = 0, iod = 0, sa = 0;
    logic [2:0] sb = 3'b000;
    logic [1:0] op = 2'b00;
    logic ps = 0, rd = 0, m2r = 0, h = 0, il = 0;
    case (p)
      ST_FETCH:    begin mrd = 1; sb = 3'b001; irw = WAIT_EN ? mr : 1'b1; pcw = irw; end
      ST_DECODE:   sb = 3'b010;
      ST_EXEC_R:   begin sa = 1; op = 2'b10; end
      ST_WB_R:     begin rw = 1; rd = 1; end
      ST_EXEC_I:   begin sa = 1; sb = 3'b010; end
      ST_EXEC_LHI: begin sb = 3'b100; op = 2'b11; end
      ST_WB_I:     rw = 1;
      ST_ADDR:     begin sa = 1; sb = 3'b010; end
      ST_MEM_RD:   begin mrd = 1; iod = 1; end
      ST_WB_MEM:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin mwr = 1; iod = 1; end
      ST_BRANCH:   begin sa = 1; op = 2'b01; pcwc = 1; ps = 1; end
      ST_JUMP:     begin sb = 3'b101; pcw = 1; end
      ST_HALT:     h = 1;
      ST_ILLEGAL:  begin h = 1; il = 1; end
      default:     h = 0;
    endcase
    return {pcw, pcwc, irw, rw, mrd, mwr, iod, sa, sb, op, ps, rd, m2r, h, il};
  endfunction

  // mode 0: mem_ready=1, 1: random, 2: always 0. stall_mem forces waits in MEM_RD/MEM_WR.
  task automatic run_instr(input logic [3:0] op, input int mode, input int stall_mem,
                           output int cycles);
    state_t ph[$];
    int stall;
    int hold;
    bit adv;
    bit is_mem;
    logic mr;
    ph.push_back(ST_FETCH);
    ph.push_back(ST_DECODE);
    if (op <= 4'd3) begin ph.push_back(ST_EXEC_R); ph.push_back(ST_WB_R); end
    else if (op == 4'd4) begin ph.push_back(ST_EXEC_I); ph.push_back(ST_WB_I); end
    else if (op == 4'd9) begin ph.push_back(ST_EXEC_LHI); ph.push_back(ST_WB_I); end
    else if (op == 4'd5) begin ph.push_back(ST_ADDR); ph.push_back(ST_MEM_RD); ph.push_back(ST_WB_MEM); end
    else if (op == 4'd6) begin ph.push_back(ST_ADDR); ph.push_back(ST_MEM_WR); end
    else if (op == 4'd7) ph.push_back(ST_BRANCH);
    else if (op == 4'd8) ph.push_back(ST_JUMP);
    else if (op == 4'hF) ph.push_back(ST_HALT);
    else ph.push_back(ST_ILLEGAL);
    cycles = 0;
    stall = stall_mem;
    hold = 0;
    foreach (ph[i]) begin
      adv = 1'b0;
      while (!adv) begin
        is_mem = (ph[i] == ST_FETCH) || (ph[i] == ST_MEM_RD) || (ph[i] == ST_MEM_WR);
        if ((ph[i] == ST_MEM_RD || ph[i] == ST_MEM_WR) && stall > 0) begin
          mr = 1'b0;
          stall--;
        end else if (mode == 0) mr = 1'b1;
        else if (mode == 1) mr = 1'($urandom_range(0, 1));
        else mr = 1'b0;
        mem_ready = mr;
        opcode = (ph[i] == ST_DECODE) ? op : 4'($urandom);
        zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        total++;
        if (state !== 4'(ph[i])) begin
          bad++;
          $display("FAIL state op=%h cyc=%0d got=%0d want=%0d", op, cycles, state, ph[i]);
        end
        total++;
        if (obs !== exp_ctrl(ph[i], mr)) begin
          bad++;
          $display("FAIL ctrl op=%h phase=%0d mr=%b got=%h want=%h", op, ph[i], mr, obs,
                   exp_ctrl(ph[i], mr));
        end
        cycles++;
        if (ph[i] == ST_HALT || ph[i] == ST_ILLEGAL) begin
          hold++;
          adv = (hold >= 10);
        end else begin
          adv = !(is_mem && WAIT_EN && !mr);
        end
        if (cycles > 200) begin
          bad++;
          $display("FAIL timeout op=%h got=%0d cycles want<=200", op, cycles);
          adv = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      opcode = 4'($urandom);
      @(negedge clk);
      total++;
      if (state !== 4'd0 || obs !== 19'd0) begin
        bad++;
        $display("FAIL reset got state=%0d ctrl=%h want state=0 ctrl=0", state, obs);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_directed(input logic [3:0] op, input int stall, input int want,
                               input string name);
    int c;
    run_instr(op, 0, stall, c);
    total++;
    if (c !== want) begin
      bad++;
      $display("FAIL latency_%s got=%0d want=%0d", name, c, want);
    end
  endtask

  task automatic test_random();
    logic [3:0] legal[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    int c;
    for (int n = 0; n < 40; n++) run_instr(legal[$urandom_range(0, 9)], 1, 0, c);
  endtask

  task automatic test_reset_mem_wr();
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    mem_ready = 1'b1;
    opcode = OP_SW;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 4'd10 || mem_write !== 1'b1) begin
      bad++;
      $display("FAIL memwr_enter got state=%0d mem_write=%b want 10/1", state, mem_write);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      bad++;
      $display("FAIL memwr_rst got mem_write=%b state=%0d want 0/0", mem_write, state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 4'd0 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      bad++;
      $display("FAIL memwr_refetch got state=%0d rd=%b wr=%b want 0/1/0", state, mem_read,
               mem_write);
    end
    @(posedge clk); #1;
`else
    int c;
    run_instr(OP_SW, 2, 0, c);
    total++;
    if (c !== 4) begin
      bad++;
      $display("FAIL sw_nowait got=%0d want=4", c);
    end
`endif
  endtask

  task automatic test_trap(input logic [3:0] op);
    int c;
    run_instr(op, 1, 0, c);
    test_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed(4'd0, 0, 4, "add");
    test_directed(4'd5, 2, WAIT_EN ? 7 : 5, "lw_stall");
    test_directed(4'd7, 0, 3, "beq");
    test_directed(4'd8, 0, 3, "jmp");
    test_directed(4'd9, 0, 4, "lhi");
    test_directed(4'd6, 0, 4, "sw");
    test_random();
    test_reset_mem_wr();
    test_trap(4'hF);
    test_trap(4'hA);
    test_trap(4'hC);
    test_directed(4'd4, 0, 4, "addi");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the 16-bit RISC datapath. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives every datapath select and write enable, including the 3-bit ALU B-source select. Sits beside the datapath and takes only the IR opcode, the ALU zero flag and a memory ready handshake.

## Interface
Parameters:
- none (all encodings are in the shared package)

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  4  ir[15:12] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write, pc_write_cond, ir_write, reg_write  out  1 each  write enables
- mem_read, mem_write  out  1 each  memory strobes
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- alu_srcA  out  1  ALU A source: 0 = PC, 1 = A
- alu_srcB  out  3  ALU B source:
  - 000 = B
  - 001 = 16'd1
  - 010 = sext(ir[5:0])
  - 100 = {ir[7:0], 8'h00}
  - 101 = sext(ir[11:0])
- alu_op  out  2  ALU operation: 00 ADD, 01 SUB, 10 FUNC (ALU decodes opcode[1:0]), 11 PASSB
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut
- reg_dst  out  1  destination register: 0 = ir[11:9], 1 = ir[5:3]
- mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- halted  out  1  core stopped (HALT or ILLEGAL)
- illegal  out  1  undefined opcode trapped
- state  out  4  current state, for debug

## Operation
Opcodes:
- 0000–0011 ADD/SUB/AND/OR (R-type)
- 0100 ADDI
- 0101 LW
- 0110 SW
- 0111 BEQ
- 1000 JMP
- 1001 LHI
- 1111 HALT
- anything else is illegal

Outputs are Moore outputs, decoded from the state register. Any output not listed for a state is 0.

States:
- FETCH: mem_read, i_or_d=0, alu_srcA=0, alu_srcB=001, ADD, pc_src=0.
  - ir_write and pc_write pulse only in the cycle mem_ready=1; that cycle goes to DECODE, otherwise hold.
- DECODE: alu_srcA=0, alu_srcB=010, ADD (branch target PC+1+imm6 into ALUOut). Next state by opcode:
  - R-type → EXEC_R
  - ADDI → EXEC_I
  - LHI → EXEC_LHI
  - LW/SW → ADDR
  - BEQ → BRANCH
  - JMP → JUMP
  - HALT → HALT
  - other → ILLEGAL
- EXEC_R: alu_srcA=1, alu_srcB=000, FUNC → WB_R.
- WB_R: reg_write, reg_dst=1, mem_to_reg=0 → FETCH.
- EXEC_I: alu_srcA=1, alu_srcB=010, ADD → WB_I.
- EXEC_LHI: alu_srcB=100, PASSB → WB_I.
- WB_I: reg_write, reg_dst=0, mem_to_reg=0 → FETCH.
- ADDR: alu_srcA=1, alu_srcB=010, ADD → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read, i_or_d=1; wait for mem_ready → WB_MEM.
- WB_MEM: reg_write, reg_dst=0, mem_to_reg=1 → FETCH.
- MEM_WR: mem_write, i_or_d=1; wait for mem_ready → FETCH.
- BRANCH: alu_srcA=1, alu_srcB=000, SUB, pc_write_cond, pc_src=1 → FETCH. The datapath writes PC when zero=1.
- JUMP: alu_srcA=0, alu_srcB=101, ADD, pc_write, pc_src=0 → FETCH.
- HALT: halted=1; sticky until rst.
- ILLEGAL: halted=1, illegal=1; sticky until rst.

Rules:
- opcode is sampled only in DECODE.
- zero is not used by the FSM.

## Timing
- Reset: while rst=1, every output is forced to 0 combinationally. state reads 0 (FETCH encoding). On the first edge with rst=0, FETCH becomes active.
- rst has priority over mem_ready and every transition. Reset during a MEM_WR wait drops mem_write in the same cycle, and no write completes.
- Latency with zero-wait memory (mem_ready tied 1), in cycles:
  - R-type, ADDI, LHI: 4
  - LW: 5
  - SW: 4
  - BEQ, JMP: 3
- Each memory wait cycle adds 1 cycle.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Memory handshake: strobes stay asserted and addresses stable until the cycle with mem_ready=1; that is the last cycle of the access.

## Configuration
- MULTICYCLE_CTRL_MEM_WAIT_EN defined: the mem_ready handshake behaves as described above.
- MULTICYCLE_CTRL_MEM_WAIT_EN undefined: mem_ready is ignored and treated as 1. FETCH, MEM_RD and MEM_WR last exactly one cycle, and ir_write/pc_write assert for the whole FETCH cycle.

## Structure
- Package risc_ctrl_pkg holds:
  - state encodings (4-bit, FETCH=0)
  - opcode constants
  - alu_srcB codes
  - alu_op codes
- The datapath and its bench import the same package.
- One sub-module, ctrl_out_decode: combinational map from state to the output control word.
- multicycle_ctrl keeps the state register, next-state logic and reset override.

## Test plan
- ADD, mem_ready=1 → state sequence 0,DECODE,EXEC_R,WB_R,0. alu_srcB=001,010,000 in the first three states. reg_write=1 only in WB_R.
- LW with mem_ready low for 2 cycles in MEM_RD → mem_read and i_or_d=1 held 3 cycles, then WB_MEM with mem_to_reg=1. Total 7 cycles.
- BEQ → BRANCH shows alu_op=01, pc_write_cond=1, pc_src=1, pc_write=0.
- JMP → JUMP shows alu_srcB=101, pc_write=1. LHI → EXEC_LHI shows alu_srcB=100, alu_op=11.
- Opcode 1010 → ILLEGAL with halted=1 and illegal=1, held for 10 cycles. rst pulse → FETCH, both flags 0.
- rst asserted during a MEM_WR wait → mem_write 0 in that cycle, then FETCH. Without the macro, SW takes 4 cycles with mem_ready=0.
